dpd_fb_align: RTL
=================

# dpd_fb_align

Feedback-path delay estimator and aligner that sits directly upstream of the `dpd` feedback inputs (`sig_pa_i`/`sig_pa_q`). On a start request it captures a burst of the transmitted signal and the PA feedback, then finds the loop lag (0..MAX_LAG) by sequential cross-correlation of magnitude proxies. After that it delays the feedback by `MAX_LAG - lag`, so the total reference-to-`fb_out` delay is constant and `dpd`'s fixed `DELAY` parameter stays valid across boards and temperature.

## Interface
- `W`, 20: sample width (signed, two's complement).
- `N_CAP`, 256: correlation window length in samples; power of two.
- `MAX_LAG`, 63: largest lag searched.
- `PEAK_MIN`, 40'd1<<20: minimum accepted correlation peak (used only with `DPD_ALIGN_PEAK_CHECK_EN`).

- `clk` in 1: clock; all logic is on the rising edge.
- `reset_b` in 1: asynchronous active-low reset.
- `start` in 1: level input; a rising edge (registered internally, as for `dpd_adapt`) requests a measurement.
- `ref_i`, `ref_q` in W: signal sent to the PA (the `dpd` `sig_out`).
- `fb_i`, `fb_q` in W: feedback from the ADC.
- `fb_out_i`, `fb_out_q` out W: aligned feedback to `dpd` `sig_pa_*`.
- `lag_est` out 6 (clog2(MAX_LAG+1)): current accepted lag.
- `corr_peak` out 40: peak correlation value of the last measurement.
- `busy` out 1: measurement in progress.
- `done` out 1: one-cycle pulse when a measurement completes.
- `fail` out 1: sticky flag; the last measurement was rejected.

## Operation
- Magnitude proxy: `m = (|i| + |q|) >> (W-15)`, giving a 16-bit unsigned value. `|-2^(W-1)|` saturates to `2^(W-1)-1`.
- Storage: a reference RAM of N_CAP x 16 bits and a feedback RAM of (N_CAP+MAX_LAG) x 16 bits.
- FSM states: IDLE, CAPTURE, CORR, DONE.
  - IDLE: `busy=0`. A detected rising edge of `start` moves the FSM to CAPTURE.
  - CAPTURE: runs for N_CAP+MAX_LAG cycles. Cycle k (0-based) writes `fb[k]`. For k < N_CAP it also writes `ref[k]`. It then moves to CORR with L=0.
  - CORR: for each L in 0..MAX_LAG, accumulate `acc = sum_{n=0}^{N_CAP-1} ref[n]*fb[n+L]`.
    - One read-address pair is issued per cycle.
    - Pipeline: RAM read (1) + 16x16 multiply (1); the accumulator is 40 bits and does not wrap.
    - Each lag takes N_CAP+2 cycles including the flush.
    - At the end of each lag: if `acc > best` (strict), then `best=acc` and `best_lag=L`. `best` is cleared when CORR is entered. Ties therefore keep the smallest lag.
    - After L=MAX_LAG the FSM moves to DONE.
  - DONE: lasts 1 cycle. It sets `corr_peak=best`, pulses `done`, applies the acceptance rule and returns to IDLE.
- Acceptance: the result is accepted unless the peak check rejects it (see Configuration). On accept, `lag_est<=best_lag` and `fail<=0`. On reject, `lag_est` is unchanged and `fail<=1`.
- `start` edges seen while `busy=1` are ignored and are not queued.
- Delay line: a circular buffer of depth MAX_LAG+1, written every cycle regardless of FSM state.
  - `fb_out` = `fb` delayed by `MAX_LAG - lag_est + 1` cycles; the output is registered.
  - A new `lag_est` takes effect on the cycle after DONE. Samples may repeat or skip at that switch; this is acceptable because `dpd` is only adapted afterwards.

## Timing
- Reset values: `fb_out_i`/`fb_out_q`=0, `lag_est`=0, `corr_peak`=0, `busy`=0, `done`=0, `fail`=0, FSM=IDLE, delay buffer cleared.
- Start sampling:
  - `start` passes through 2 flops. The edge is seen at cycle t.
  - Capture index 0 is the `ref`/`fb` values present at cycle t+1.
  - `busy` rises at t+1.
- `done` is asserted at cycle t+1 + (N_CAP+MAX_LAG) + (MAX_LAG+1)(N_CAP+2). This is 16,831 cycles for the default parameters. `busy` falls in the same cycle.
- `lag_est`, `corr_peak` and `fail` are valid in the `done` cycle and hold until the next `done`.
- Reset mid-operation: everything returns to reset values, and the partial measurement is discarded.
- Total `ref`-to-`fb_out` alignment: a PA loop lag of D (≤ MAX_LAG) yields `fb_out` = `ref` delayed by MAX_LAG+1 cycles. The `dpd` `DELAY` parameter is set accordingly.

## Configuration
- `DPD_ALIGN_PEAK_CHECK_EN` defined: a result with `best < PEAK_MIN` is rejected (`fail=1`, `lag_est` held).
- `DPD_ALIGN_PEAK_CHECK_EN` undefined: every measurement is accepted, `fail` is tied to 0, and `PEAK_MIN` is unused.

## Test plan
- Reset: assert `reset_b`=0 mid-stream, then release. All outputs read 0, `fb_out` equals `fb` delayed by 64 cycles, and `busy`=0.
- Lag 17: `ref` = random bursts with |i|,|q| ≤ 2^18, `fb` = `ref` delayed by 17 cycles, raise `start`. `done` fires at t+16,832, `lag_est`=17, `fail`=0, and afterwards `fb_out` equals `ref` delayed by 64 cycles.
- Boundaries:
  - `fb` delay 0 gives `lag_est`=0.
  - `fb` delay 63 gives `lag_est`=63, and `fb_out` equals `fb` delayed by 1 cycle.
- Zero feedback (`fb`=0):
  - With the macro: `fail`=1, `corr_peak`=0, `lag_est` keeps its previous value of 17.
  - Without the macro: `lag_est`=0 (tie rule).
- Re-trigger: toggle `start` 1000 cycles into CORR. There is no second measurement, and exactly one `done` pulse occurs.
- Reset during CORR: pull `reset_b` low at cycle t+5000, then restart. The new measurement completes with the correct lag and no residue from the aborted run.

Source files
------------

// File: rtl/dpd_fb_align.sv
// dpd_fb_align: measures the PA feedback loop lag by magnitude cross-correlation and delays fb so ref-to-fb_out is constant.
// Optional macro DPD_ALIGN_PEAK_CHECK_EN rejects measurements whose correlation peak is below PEAK_MIN.

module dpd_fb_align #(
  parameter int          W        = 20,
  parameter int          N_CAP    = 256,
  parameter int          MAX_LAG  = 63,
  parameter logic [39:0] PEAK_MIN = 40'd1 << 20,
  localparam int         LW       = $clog2(MAX_LAG + 1)
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                start,
  input  logic signed [W-1:0] ref_i,
  input  logic signed [W-1:0] ref_q,
  input  logic signed [W-1:0] fb_i,
  input  logic signed [W-1:0] fb_q,
  output logic signed [W-1:0] fb_out_i,
  output logic signed [W-1:0] fb_out_q,
  output logic [LW-1:0]       lag_est,
  output logic [39:0]         corr_peak,
  output logic                busy,
  output logic                done,
  output logic                fail
);

  // state   | meaning
  // IDLE    | waiting for a start rising edge
  // CAPTURE | writing N_CAP ref and N_CAP+MAX_LAG fb magnitudes
  // CORR    | one lag per N_CAP+2 cycles, tracking the strict maximum
  // DONE    | single cycle: done pulse, results already registered
  typedef enum logic [1:0] {IDLE, CAPTURE, CORR, DONE} state_t;

  localparam int FB_DEPTH = N_CAP + MAX_LAG;
  localparam int AW_REF   = $clog2(N_CAP);
  localparam int AW_FB    = $clog2(FB_DEPTH);
  localparam int CW       = $clog2(FB_DEPTH + N_CAP);
  localparam int DEPTH    = MAX_LAG + 1;
  localparam int PW       = $clog2(DEPTH);

  localparam logic [CW-1:0] CAP_LAST  = CW'(FB_DEPTH - 1);
  localparam logic [CW-1:0] CORR_LAST = CW'(N_CAP + 1);
  localparam logic [CW-1:0] N_CAP_C   = CW'(N_CAP);
  localparam logic [LW-1:0] LAG_LAST  = LW'(MAX_LAG);
  localparam logic [PW:0]   DEPTH_C   = (PW+1)'(DEPTH);

  function automatic logic [W-2:0] abs_sat(input logic signed [W-1:0] x);
    if (!x[W-1])           return (W-1)'(x);
    if (x[W-2:0] == '0)    return {(W-1){1'b1}};
    return (W-1)'(-x);
  endfunction

  function automatic logic [15:0] mag_proxy(input logic signed [W-1:0] i,
                                            input logic signed [W-1:0] q);
    logic [W-1:0] s;
    s = {1'b0, abs_sat(i)} + {1'b0, abs_sat(q)};
    return 16'(s >> (W-15));
  endfunction

  state_t          state_q, state_d;
  logic            start_s1_q, start_s2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   lag_q, lag_d;
  logic [39:0]     acc_q, acc_d;
  logic [39:0]     best_q, best_d;
  logic [LW-1:0]   best_lag_q, best_lag_d;
  logic            v1_q, v1_d, v2_q, v2_d;
  logic [31:0]     prod_q, prod_d;
  logic [LW-1:0]   lag_est_q, lag_est_d;
  logic [39:0]     corr_peak_q, corr_peak_d;
  logic [W-1:0]    fb_out_i_q, fb_out_i_d, fb_out_q_q, fb_out_q_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [15:0]     ref_mem [N_CAP];
  logic [15:0]     fb_mem  [FB_DEPTH];
  logic [15:0]     ref_rd_q, fb_rd_q;
  logic [W-1:0]    dline_i_q [DEPTH];
  logic [W-1:0]    dline_q_q [DEPTH];

  logic            start_edge;
  logic            ref_we, fb_we;
  logic [AW_REF-1:0] ref_addr;
  logic [AW_FB-1:0]  fb_addr;
  logic [39:0]     acc_sum, best_nxt;
  logic [LW-1:0]   best_lag_nxt;
  logic            accept;
  logic [LW-1:0]   tap;
  logic [PW:0]     rd_wide;
  logic [PW-1:0]   rd_ptr;

  assign start_edge   = start_s1_q & ~start_s2_q;
  assign acc_sum      = acc_q + 40'(prod_q);
  assign best_nxt     = (acc_sum > best_q) ? acc_sum : best_q;
  assign best_lag_nxt = (acc_sum > best_q) ? lag_q : best_lag_q;

`ifdef DPD_ALIGN_PEAK_CHECK_EN
  logic fail_q, fail_d;
  assign accept = (best_nxt >= PEAK_MIN);
  assign fail   = fail_q;
`else
  logic unused_peak_min;
  assign accept          = 1'b1;
  assign unused_peak_min = ^PEAK_MIN;
  assign fail            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lag_d       = lag_q;
    acc_d       = acc_q;
    best_d      = best_q;
    best_lag_d  = best_lag_q;
    v1_d        = 1'b0;
    v2_d        = v1_q;
    prod_d      = 32'(ref_rd_q) * 32'(fb_rd_q);
    lag_est_d   = lag_est_q;
    corr_peak_d = corr_peak_q;
`ifdef DPD_ALIGN_PEAK_CHECK_EN
    fail_d      = fail_q;
`endif
    ref_we      = 1'b0;
    fb_we       = 1'b0;
    ref_addr    = '0;
    fb_addr     = '0;

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE: begin
        fb_we    = 1'b1;
        ref_we   = (cnt_q < N_CAP_C);
        ref_addr = AW_REF'(cnt_q);
        fb_addr  = AW_FB'(cnt_q);
        if (cnt_q == CAP_LAST) begin
          state_d    = CORR;
          cnt_d      = '0;
          lag_d      = '0;
          acc_d      = '0;
          best_d     = '0;
          best_lag_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CORR: begin
        if (cnt_q < N_CAP_C) begin
          v1_d     = 1'b1;
          ref_addr = AW_REF'(cnt_q);
          fb_addr  = AW_FB'(cnt_q + CW'(lag_q));
        end
        if (v2_q) acc_d = acc_sum;
        if (cnt_q == CORR_LAST) begin
          // Last product of this lag is still in prod_q, so compare the folded sum.
          cnt_d      = '0;
          acc_d      = '0;
          best_d     = best_nxt;
          best_lag_d = best_lag_nxt;
          if (lag_q == LAG_LAST) begin
            state_d     = DONE;
            corr_peak_d = best_nxt;
            if (accept) lag_est_d = best_lag_nxt;
`ifdef DPD_ALIGN_PEAK_CHECK_EN
            fail_d      = ~accept;
`endif
          end else begin
            lag_d = lag_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Delay line tap: MAX_LAG - lag_est slots back, zero meaning the live input.
  always_comb begin
    wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    tap      = LAG_LAST - lag_est_q;
    rd_wide  = {1'b0, wr_ptr_q} + DEPTH_C - {1'b0, tap};
    if (rd_wide >= DEPTH_C) rd_wide = rd_wide - DEPTH_C;
    rd_ptr   = rd_wide[PW-1:0];
    if (tap == '0) begin
      fb_out_i_d = fb_i;
      fb_out_q_d = fb_q;
    end else begin
      fb_out_i_d = dline_i_q[rd_ptr];
      fb_out_q_d = dline_q_q[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      start_s1_q  <= 1'b0;
      start_s2_q  <= 1'b0;
      cnt_q       <= '0;
      lag_q       <= '0;
      acc_q       <= '0;
      best_q      <= '0;
      best_lag_q  <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      prod_q      <= '0;
      lag_est_q   <= '0;
      corr_peak_q <= '0;
      fb_out_i_q  <= '0;
      fb_out_q_q  <= '0;
      wr_ptr_q    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dline_i_q[k] <= '0;
        dline_q_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      start_s1_q  <= start;
      start_s2_q  <= start_s1_q;
      cnt_q       <= cnt_d;
      lag_q       <= lag_d;
      acc_q       <= acc_d;
      best_q      <= best_d;
      best_lag_q  <= best_lag_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      prod_q      <= prod_d;
      lag_est_q   <= lag_est_d;
      corr_peak_q <= corr_peak_d;
      fb_out_i_q  <= fb_out_i_d;
      fb_out_q_q  <= fb_out_q_d;
      wr_ptr_q    <= wr_ptr_d;
      dline_i_q[wr_ptr_q] <= fb_i;
      dline_q_q[wr_ptr_q] <= fb_q;
    end
  end

`ifdef DPD_ALIGN_PEAK_CHECK_EN
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) fail_q <= 1'b0;
    else          fail_q <= fail_d;
  end
`endif

  // Capture buffers carry no reset; every entry read is rewritten by CAPTURE first.
  always_ff @(posedge clk) begin
    if (ref_we) ref_mem[ref_addr] <= mag_proxy(ref_i, ref_q);
    if (fb_we)  fb_mem[fb_addr]   <= mag_proxy(fb_i, fb_q);
    ref_rd_q <= ref_mem[ref_addr];
    fb_rd_q  <= fb_mem[fb_addr];
  end

  assign busy      = (state_q == CAPTURE) || (state_q == CORR);
  assign done      = (state_q == DONE);
  assign lag_est   = lag_est_q;
  assign corr_peak = corr_peak_q;
  assign fb_out_i  = fb_out_i_q;
  assign fb_out_q  = fb_out_q_q;

endmodule
